// File: rtl/ecore_lsu_pkg.sv
// Shared definitions for the ecore load/store unit: funct3 codes, FSM states,
// GPIO window layout, and the request decode / load-extend helpers.
package ecore_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [3:0] GPIO_OFF_OUT = 4'h0;
   localparam logic [3:0] GPIO_OFF_DIR = 4'h4;
   localparam logic [3:0] GPIO_OFF_IN  = 4'h8;
   localparam logic [3:0] GPIO_SIZE    = 4'd12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef struct packed {
      logic        fault;
      logic        gpio;
      logic [3:0]  be;
      logic [31:0] wdata;
   } dec_t;

   // The GPIO window decodes on a 16-byte boundary; offsets 12..15 fault.
   function automatic dec_t decode(input logic        store,
                                   input logic [2:0]  funct3,
                                   input logic [31:0] addr,
                                   input logic [31:0] wdata,
                                   input logic        gpio_en,
                                   input logic [31:0] gpio_base);
      dec_t d;
      d.gpio = gpio_en && (addr[31:4] == gpio_base[31:4]);
      if (store)
         d.fault = (funct3 >= 3'd3);
      else
         d.fault = (funct3[1:0] == 2'b11) || (funct3 == 3'd6);
      if (funct3[1:0] == 2'b01 && addr[0])
         d.fault = 1'b1;
      if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
         d.fault = 1'b1;
      if (d.gpio && ((funct3 != F3_W) || (addr[3:0] >= GPIO_SIZE) ||
                     (store && addr[3:0] == GPIO_OFF_IN)))
         d.fault = 1'b1;
      case (funct3[1:0])
         2'b00: begin
            d.be    = 4'b0001 << addr[1:0];
            d.wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            d.be    = addr[1] ? 4'b1100 : 4'b0011;
            d.wdata = {2{wdata[15:0]}};
         end
         default: begin
            d.be    = 4'b1111;
            d.wdata = wdata;
         end
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (funct3)
         F3_B:    return {{24{sh[7]}}, sh[7:0]};
         F3_H:    return {{16{sh[15]}}, sh[15:0]};
         F3_BU:   return {24'h0, sh[7:0]};
         F3_HU:   return {16'h0, sh[15:0]};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/ecore_lsu_gpio.sv
// GPIO register block: OUT/DIR registers, 2-flop synchronized IN, per-pin
// tristate drivers. Only instantiated when ECORE_LSU_GPIO_EN is defined.
module ecore_gpio
   import ecore_lsu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_we,
   input  logic [1:0]  i_sel,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   inout  wire  [31:0] io_pins
);

   logic [31:0] out_reg;
   logic [31:0] dir_reg;
   logic [31:0] sync1_reg;
   logic [31:0] in_reg;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         out_reg   <= '0;
         dir_reg   <= '0;
         sync1_reg <= '0;
         in_reg    <= '0;
      end else begin
         sync1_reg <= io_pins;
         in_reg    <= sync1_reg;
         if (i_we && i_sel == GPIO_OFF_OUT[3:2])
            out_reg <= i_wdata;
         if (i_we && i_sel == GPIO_OFF_DIR[3:2])
            dir_reg <= i_wdata;
      end
   end

   always_comb begin
      o_rdata = '0;
      case (i_sel)
         GPIO_OFF_OUT[3:2]: o_rdata = out_reg;
         GPIO_OFF_DIR[3:2]: o_rdata = dir_reg;
         GPIO_OFF_IN[3:2]:  o_rdata = in_reg;
         default:           o_rdata = '0;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_pin
         assign io_pins[gi] = dir_reg[gi] ? out_reg[gi] : 1'bz;
      end
   endgenerate

endmodule

// File: rtl/ecore_lsu.sv
// RV32I load/store unit: single-outstanding request FSM driving a word RAM
// and an optional memory-mapped GPIO window (enabled by ECORE_LSU_GPIO_EN).
module ecore_lsu
   import ecore_lsu_pkg::*;
#(
   parameter logic [31:0] GPIO_BASE = 32'h8000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_store,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_fault,
   output logic [29:0] o_ram_addr,
   output logic [31:0] o_ram_wdata,
   output logic        o_ram_we,
   output logic [3:0]  o_ram_be,
   input  logic [31:0] i_ram_rdata,
   inout  wire  [31:0] io_gpio_bank
);

`ifdef ECORE_LSU_GPIO_EN
   localparam logic GPIO_EN = 1'b1;
`else
   localparam logic GPIO_EN = 1'b0;
`endif

   state_t      state_reg, state_next;
   dec_t        dec;
   logic        accept;
   logic        store_reg;
   logic        fault_reg;
   logic        gpio_reg;
   logic [2:0]  funct3_reg;
   logic [1:0]  lane_reg;
   logic [31:0] gpio_rdata;

   assign o_req_ready = (state_reg == IDLE);
   assign accept      = i_req_valid && o_req_ready;
   assign dec         = decode(i_req_store, i_req_funct3, i_req_addr, i_req_wdata,
                               GPIO_EN, GPIO_BASE);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (i_req_valid) state_next = ACCESS;
         ACCESS:  state_next = (!store_reg && !fault_reg && !gpio_reg) ? WAIT : RESP;
         WAIT:    state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // RAM port outputs are registered at the accept edge so they are stable
   // for the whole ACCESS cycle; o_ram_we self-clears one edge later.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg   <= IDLE;
         store_reg   <= 1'b0;
         fault_reg   <= 1'b0;
         gpio_reg    <= 1'b0;
         funct3_reg  <= '0;
         lane_reg    <= '0;
         o_rsp_valid <= 1'b0;
         o_rsp_fault <= 1'b0;
         o_rsp_rdata <= '0;
         o_ram_we    <= 1'b0;
         o_ram_be    <= '0;
         o_ram_addr  <= '0;
         o_ram_wdata <= '0;
      end else begin
         state_reg   <= state_next;
         o_ram_we    <= 1'b0;
         o_rsp_valid <= 1'b0;
         if (accept) begin
            store_reg   <= i_req_store;
            fault_reg   <= dec.fault;
            gpio_reg    <= dec.gpio;
            funct3_reg  <= i_req_funct3;
            lane_reg    <= i_req_addr[1:0];
            o_ram_addr  <= i_req_addr[31:2];
            o_ram_be    <= dec.be;
            o_ram_wdata <= dec.wdata;
            o_ram_we    <= i_req_store && !dec.fault && !dec.gpio;
         end
         if (state_reg == ACCESS && state_next == RESP) begin
            o_rsp_valid <= 1'b1;
            o_rsp_fault <= fault_reg;
            o_rsp_rdata <= (gpio_reg && !store_reg && !fault_reg) ? gpio_rdata : '0;
         end
         if (state_reg == WAIT) begin
            o_rsp_valid <= 1'b1;
            o_rsp_fault <= 1'b0;
            o_rsp_rdata <= load_extend(funct3_reg, lane_reg, i_ram_rdata);
         end
      end
   end

`ifdef ECORE_LSU_GPIO_EN
   logic [31:0] wdata_reg;
   logic [1:0]  sel_reg;
   logic        gpio_we;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wdata_reg <= '0;
         sel_reg   <= '0;
      end else if (accept) begin
         wdata_reg <= i_req_wdata;
         sel_reg   <= i_req_addr[3:2];
      end
   end

   // Write lands on the ACCESS->RESP edge.
   assign gpio_we = (state_reg == ACCESS) && gpio_reg && store_reg && !fault_reg;

   ecore_gpio u_gpio (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (gpio_we),
      .i_sel   (sel_reg),
      .i_wdata (wdata_reg),
      .o_rdata (gpio_rdata),
      .io_pins (io_gpio_bank)
   );
`else
   assign gpio_rdata   = '0;
   assign io_gpio_bank = 'z;
`endif

endmodule

// File: tb/tb_ecore_lsu.sv
// Scoreboard bench for ecore_lsu: expected responses and RAM writes are queued
// at stimulus time and compared when the DUT produces them.
module tb_ecore_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic [29:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_rdata = '0;
   tri   [31:0] gpio_pins;

   always #5 clk = ~clk;

   ecore_lsu dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_store  (req_store),
      .i_req_funct3 (req_funct3),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_rdata  (rsp_rdata),
      .o_rsp_fault  (rsp_fault),
      .o_ram_addr   (ram_addr),
      .o_ram_wdata  (ram_wdata),
      .o_ram_we     (ram_we),
      .o_ram_be     (ram_be),
      .i_ram_rdata  (ram_rdata),
      .io_gpio_bank (gpio_pins)
   );

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        fault;
      int          lat;
      int          acc;
   } exp_t;

   typedef struct {
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } wexp_t;

   exp_t  rsp_q[$];
   wexp_t we_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc = 0;
   int last_rsp = 0;
   int we_count = 0;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

`ifdef ECORE_LSU_GPIO_EN
   localparam bit GPIO_ON = 1'b1;
   logic        tb_drv = 1'b0;
   assign gpio_pins[31:8] = tb_drv ? 24'h0 : 24'hz;
`else
   localparam bit GPIO_ON = 1'b0;
`endif
   logic [31:0] g_out = '0;
   logic [31:0] g_dir = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Word RAM with one-cycle registered read and byte-enabled write.
   always @(posedge clk) begin
      ram_rdata <= mem[ram_addr[7:0]];
      if (ram_we)
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
   end

   always @(negedge clk) begin
      exp_t  e;
      wexp_t w;
      if (rsp_valid) begin
         if (rsp_q.size() == 0) begin
            check("unexpected_rsp", {31'h0, rsp_valid}, 32'h0);
         end else begin
            e = rsp_q.pop_front();
            check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
            check({e.tag, "_fault"}, {31'h0, rsp_fault}, {31'h0, e.fault});
            check({e.tag, "_lat"}, cyc + 1 - e.acc, e.lat);
            $display("rsp %-10s rdata=%h fault=%0d lat=%0d", e.tag, rsp_rdata, rsp_fault, cyc + 1 - e.acc);
         end
         last_rsp = cyc + 1;
      end
      if (ram_we) begin
         we_count++;
         if (we_q.size() == 0) begin
            check("unexpected_we", {31'h0, ram_we}, 32'h0);
         end else begin
            w = we_q.pop_front();
            check("we_addr", {2'b00, ram_addr}, {2'b00, w.addr});
            check("we_be", {28'h0, ram_be}, {28'h0, w.be});
            check("we_wdata", ram_wdata, w.wdata);
         end
      end
   end

   // Reference model of one access; call at a negedge, returns after the accept edge.
   task automatic issue(input string tag, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      exp_t        e;
      wexp_t       w;
      bit          flt, gp;
      logic [31:0] word;
      logic [7:0]  bv;
      logic [15:0] hv;
      int          n;
      flt = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) flt = 1'b1;
      if (f3 == 3'd2 && a[1:0] != 2'b00) flt = 1'b1;
      gp = GPIO_ON && (a[31:4] == 28'h8000000);
      if (gp && (f3 != 3'd2 || a[3:0] >= 4'd12 || (st && a[3:0] == 4'd8))) flt = 1'b1;
      e.tag = tag; e.fault = flt; e.rdata = '0;
      e.lat = (!st && !flt && !gp) ? 3 : 2;
      word = ref_mem[a[9:2]];
      bv = word[8*a[1:0] +: 8];
      hv = a[1] ? word[31:16] : word[15:0];
      if (!flt && gp) begin
         if (st && a[3:0] == 4'd0) g_out = d;
         if (st && a[3:0] == 4'd4) g_dir = d;
         if (!st) e.rdata = (a[3:0] == 4'd0) ? g_out : (a[3:0] == 4'd4) ? g_dir : (g_out & g_dir);
      end else if (!flt && st) begin
         w.addr = a[31:2];
         case (f3)
            3'd0:    begin w.be = 4'b0001 << a[1:0]; w.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]}; end
            3'd1:    begin w.be = a[1] ? 4'b1100 : 4'b0011; w.wdata = {d[15:0], d[15:0]}; end
            default: begin w.be = 4'b1111; w.wdata = d; end
         endcase
         for (int b = 0; b < 4; b++)
            if (w.be[b]) ref_mem[a[9:2]][8*b +: 8] = w.wdata[8*b +: 8];
         we_q.push_back(w);
      end else if (!flt) begin
         case (f3)
            3'd0:    e.rdata = {{24{bv[7]}}, bv};
            3'd1:    e.rdata = {{16{hv[15]}}, hv};
            3'd4:    e.rdata = {24'h0, bv};
            3'd5:    e.rdata = {16'h0, hv};
            default: e.rdata = word;
         endcase
      end
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_accept"}, {31'h0, req_ready}, 32'h1);
      e.acc = cyc + 1;
      last_acc = cyc + 1;
      rsp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      req_valid = 1'b0;
      n = 0;
      while (rsp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("drain", rsp_q.size(), 0);
   endtask

   initial begin
      int we_before;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = {i[7:0], 8'hC3, i[7:0] ^ 8'h5A, 8'h3C};
         ref_mem[i] = {i[7:0], 8'hC3, i[7:0] ^ 8'h5A, 8'h3C};
      end
      mem[8]     = 32'h8001_1234;
      ref_mem[8] = 32'h8001_1234;

      repeat (3) @(negedge clk);
      check("rst_ready", {31'h0, req_ready}, 32'h1);
      check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("rst_rsp_fault", {31'h0, rsp_fault}, 32'h0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_ram_we", {31'h0, ram_we}, 32'h0);
      check("rst_ram_be", {28'h0, ram_be}, 32'h0);
      check("rst_ram_addr", {2'b00, ram_addr}, 32'h0);
      check("rst_ram_wdata", ram_wdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      issue("sb_103", 1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5);
      issue("lh_22", 1'b0, 3'd1, 32'h0000_0022, 32'h0);
      issue("lhu_22", 1'b0, 3'd5, 32'h0000_0022, 32'h0);
      issue("lb_103", 1'b0, 3'd0, 32'h0000_0103, 32'h0);
      issue("lbu_103", 1'b0, 3'd4, 32'h0000_0103, 32'h0);
      issue("sh_12", 1'b1, 3'd1, 32'h0000_0012, 32'h1234_BEEF);
      issue("sh_14", 1'b1, 3'd1, 32'h0000_0014, 32'h0000_7E01);
      issue("lw_10", 1'b0, 3'd2, 32'h0000_0010, 32'h0);
      issue("lh_14", 1'b0, 3'd1, 32'h0000_0014, 32'h0);
      issue("sw_40", 1'b1, 3'd2, 32'h0000_0040, 32'h1234_5678);
      issue("lw_40", 1'b0, 3'd2, 32'h0000_0040, 32'h0);
      issue("lb_41", 1'b0, 3'd0, 32'h0000_0041, 32'h0);
      drain();

      we_before = we_count;
      issue("lw_6", 1'b0, 3'd2, 32'h0000_0006, 32'h0);
      issue("lh_21", 1'b0, 3'd1, 32'h0000_0021, 32'h0);
      issue("sh_23", 1'b1, 3'd1, 32'h0000_0023, 32'hFFFF_FFFF);
      issue("sw_42", 1'b1, 3'd2, 32'h0000_0042, 32'hFFFF_FFFF);
      issue("ld_f3_3", 1'b0, 3'd3, 32'h0000_0000, 32'h0);
      issue("ld_f3_6", 1'b0, 3'd6, 32'h0000_0000, 32'h0);
      issue("ld_f3_7", 1'b0, 3'd7, 32'h0000_0000, 32'h0);
      issue("st_f3_3", 1'b1, 3'd3, 32'h0000_0010, 32'hFFFF_FFFF);
      issue("st_f3_4", 1'b1, 3'd4, 32'h0000_0010, 32'hFFFF_FFFF);
      drain();
      check("fault_no_we", we_count - we_before, 0);
      issue("lw_10_after", 1'b0, 3'd2, 32'h0000_0010, 32'h0);
      drain();

`ifdef ECORE_LSU_GPIO_EN
      check("rst_pins_z", gpio_pins, 32'hzzzz_zzzz);
      issue("g_dir", 1'b1, 3'd2, 32'h8000_0004, 32'h0000_00FF);
      issue("g_out", 1'b1, 3'd2, 32'h8000_0000, 32'h0000_0055);
      drain();
      check("pins_lo", {24'h0, gpio_pins[7:0]}, 32'h0000_0055);
      check("pins_hi", {8'h0, gpio_pins[31:8]}, {8'h0, 24'hzz_zzzz});
      tb_drv = 1'b1;
      repeat (3) @(negedge clk);
      issue("g_in", 1'b0, 3'd2, 32'h8000_0008, 32'h0);
      issue("g_in_st", 1'b1, 3'd2, 32'h8000_0008, 32'h0);
      issue("g_off12", 1'b0, 3'd2, 32'h8000_000C, 32'h0);
      issue("g_sub", 1'b1, 3'd0, 32'h8000_0000, 32'h0);
      issue("g_rd_out", 1'b0, 3'd2, 32'h8000_0000, 32'h0);
      drain();
`else
      issue("win_sw", 1'b1, 3'd2, 32'h8000_0004, 32'hCAFE_F00D);
      issue("win_lw", 1'b0, 3'd2, 32'h8000_0004, 32'h0);
      drain();
`endif

      // Reset while a RAM load sits in WAIT: the response must be dropped.
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
      check("mid_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_we", {31'h0, ram_we}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         check("mid_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
         check("mid_rst_ready", {31'h0, req_ready}, 32'h1);
         @(negedge clk);
      end
      $display("reset during WAIT: no response observed");

      // Back-to-back stores with valid held high.
      we_before = we_count;
      issue("b2b_sw0", 1'b1, 3'd2, 32'h0000_0080, 32'h1111_1111);
      issue("b2b_sw1", 1'b1, 3'd2, 32'h0000_0084, 32'h2222_2222);
      check("b2b_gap", last_acc - last_rsp, 1);
      drain();
      check("b2b_we_count", we_count - we_before, 2);
      issue("b2b_lw1", 1'b0, 3'd2, 32'h0000_0084, 32'h0);
      drain();
      check("we_q_empty", we_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
